// File: rtl/sel_pkg.sv
// Types and constants shared by the select sequencer and the character mux stage.
// sel_t is the 2-bit select that all four character muxes receive in parallel.
package sel_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_FIRST = 2'b00;
  localparam sel_t SEL_LAST  = 2'b11;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// Pausing holds the partial count; clr restarts the count from zero.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             at_last;

  assign at_last = (cnt_reg == CNT_LAST);
  assign tick    = en & ~clr & at_last;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      if (at_last) begin
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/select_sequencer.sv
// Generates the registered 2-bit select that cycles the HEX displays through four characters.
// Advances come from the prescaler tick, a manual step edge, or a direct load.
module select_sequencer
  import sel_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic En,
  input  logic Dir,
  input  logic Step,
  input  logic Load,
  input  sel_t Load_val,
  output sel_t S,
  output logic Adv,
  output logic Wrap
);

  logic tick;
  logic step_q;
  logic step_req;
  logic do_adv;
  dir_e dir;
  sel_t s_next;
  logic wrap_next;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (En),
    .clr  (Load),
    .tick (tick)
  );

  // A step request while running is dropped so a step can never stack on a tick.
  always_comb begin
    dir       = dir_e'(Dir);
    step_req  = Step & ~step_q;
    do_adv    = ~Load & (tick | (~En & step_req));
    s_next    = (dir == DIR_DOWN) ? S - sel_t'(1) : S + sel_t'(1);
    wrap_next = (dir == DIR_DOWN) ? (S == SEL_FIRST) : (S == SEL_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      S      <= SEL_FIRST;
      Adv    <= 1'b0;
      Wrap   <= 1'b0;
      step_q <= 1'b0;
    end else begin
      step_q <= Step;
      if (Load) begin
        S    <= Load_val;
        Adv  <= 1'b0;
        Wrap <= 1'b0;
      end else if (do_adv) begin
        S    <= s_next;
        Adv  <= 1'b1;
        Wrap <= wrap_next;
      end else begin
        Adv  <= 1'b0;
        Wrap <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_select_sequencer.sv
// Directed bench for select_sequencer with a 4-cycle prescaler.
// Outputs are sampled 1 time unit after each rising edge, where inputs are also driven.
module tb_select_sequencer;

  logic       clk;
  logic       reset;
  logic       En;
  logic       Dir;
  logic       Step;
  logic       Load;
  logic [1:0] Load_val;
  logic [1:0] S;
  logic       Adv;
  logic       Wrap;

  int tests;
  int fails;

  select_sequencer #(
    .TICK_DIV(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .En      (En),
    .Dir     (Dir),
    .Step    (Step),
    .Load    (Load),
    .Load_val(Load_val),
    .S       (S),
    .Adv     (Adv),
    .Wrap    (Wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int observed, input int expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic chk3(input string tag, input int s_exp, input int adv_exp, input int wrap_exp);
    chk({tag, ".S"}, int'(S), s_exp);
    chk({tag, ".Adv"}, int'(Adv), adv_exp);
    chk({tag, ".Wrap"}, int'(Wrap), wrap_exp);
    $display("[TB] %s S=%0d Adv=%0d Wrap=%0d", tag, S, Adv, Wrap);
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    En       = 1'b1;
    Dir      = 1'b0;
    Step     = 1'b0;
    Load     = 1'b0;
    Load_val = 2'b00;

    // Reset state
    edges(2);
    chk3("reset", 0, 0, 0);

    // Up count from reset: advance every 4th edge, wrap at the 16th
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      edges(1);
      chk3($sformatf("up%0d", k), (k / 4) % 4, (k % 4 == 0) ? 1 : 0, (k == 16) ? 1 : 0);
    end

    // Down count from S=0
    Dir = 1'b1;
    edges(3);
    chk3("down_pre", 0, 0, 0);
    edges(1);
    chk3("down_wrap", 3, 1, 1);
    edges(3);
    chk3("down_pre2", 3, 0, 0);
    edges(1);
    chk3("down_2", 2, 1, 0);

    // Pause after 2 counts; resume finishes the remaining 2
    Dir = 1'b0;
    edges(2);
    chk3("pause_pre", 2, 0, 0);
    En = 1'b0;
    for (int k = 0; k < 10; k++) begin
      edges(1);
      chk3($sformatf("paused%0d", k), 2, 0, 0);
    end
    En = 1'b1;
    edges(1);
    chk3("resume1", 2, 0, 0);
    edges(1);
    chk3("resume2", 3, 1, 0);

    // Manual step while paused: held high gives one advance
    En   = 1'b0;
    Step = 1'b1;
    edges(1);
    chk3("step1", 0, 1, 1);
    for (int k = 0; k < 4; k++) begin
      edges(1);
      chk3($sformatf("step_hold%0d", k), 0, 0, 0);
    end
    Step = 1'b0;
    edges(1);
    chk3("step_low", 0, 0, 0);
    Step = 1'b1;
    edges(1);
    chk3("step2", 1, 1, 0);
    Step = 1'b0;
    edges(1);
    chk3("step2_after", 1, 0, 0);

    // Step edges while running are ignored, including one on the tick edge
    En   = 1'b1;
    Step = 1'b1;
    edges(1);
    chk3("run_step_mid", 1, 0, 0);
    Step = 1'b0;
    edges(2);
    chk3("run_pre_tick", 1, 0, 0);
    Step = 1'b1;
    edges(1);
    chk3("run_step_tick", 2, 1, 0);
    Step = 1'b0;
    edges(1);
    chk3("run_no_double", 2, 0, 0);

    // Load on the edge where a tick is due (cnt reached 3 after 2 more edges)
    edges(2);
    chk3("load_pre", 2, 0, 0);
    Load     = 1'b1;
    Load_val = 2'b10;
    edges(1);
    chk3("load", 2, 0, 0);
    Load     = 1'b0;
    Load_val = 2'b00;
    edges(3);
    chk3("load_after3", 2, 0, 0);
    edges(1);
    chk3("load_after4", 3, 1, 0);

    // Mid-count reset discards the partial count
    edges(2);
    chk3("rst_pre", 3, 0, 0);
    reset = 1'b1;
    edges(1);
    chk3("rst", 0, 0, 0);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      edges(1);
      chk3($sformatf("rst_cnt%0d", k), (k == 4) ? 1 : 0, (k == 4) ? 1 : 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
